// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: lock-on-grant VGA write-port arbiter with pixel register; watchdog via ARB_WATCHDOG_EN
module vga_write_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int ROUND_ROBIN = 1,
    parameter int WDOG_CYCLES = 262144
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   plot_in,
    input  logic [9*NUM_REQ-1:0] x_in,
    input  logic [8*NUM_REQ-1:0] y_in,
    input  logic [3*NUM_REQ-1:0] color_in,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 busy,
    output logic [8:0]           vga_x,
    output logic [7:0]           vga_y,
    output logic [2:0]           vga_color,
    output logic                 vga_plot,
    output logic                 timeout
);
    localparam int OW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;
    state_t state, state_nx;
    logic [OW-1:0] owner, owner_nx, rr_ptr, rr_ptr_nx, win;
    logic [NUM_REQ-1:0] elig;
    logic [8:0] ox;
    logic [7:0] oy;
    logic [2:0] oc;
    logic found, pix_ok, revoke;
    int idx;
    assign ox = x_in[9*owner +: 9];
    assign oy = y_in[8*owner +: 8];
    assign oc = color_in[3*owner +: 3];
    assign pix_ok = state == ACTIVE && plot_in[owner] && ox <= 9'd319 && oy <= 8'd239;
    assign busy = state != IDLE;
`ifdef ARB_WATCHDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic [NUM_REQ-1:0] mask;
    assign revoke = state == ACTIVE && req[owner] && cnt == CW'(WDOG_CYCLES - 1);
    assign elig = req & ~mask;
    // a revoked requester stays masked until it deasserts req for a cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt  <= '0;
            mask <= '0;
        end else begin
            cnt  <= state == ACTIVE ? cnt + 1'b1 : '0;
            mask <= (mask & req) | (revoke ? NUM_REQ'(1) << owner : '0);
        end
    end
`else
    assign revoke = 1'b0;
    assign elig = req;
`endif
    // scan from highest offset down so the closest eligible index wins
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ROUND_ROBIN != 0 ? (int'(rr_ptr) + i) % NUM_REQ : i;
            if (elig[idx]) begin
                found = 1'b1;
                win = OW'(idx);
            end
        end
    end
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        rr_ptr_nx = rr_ptr;
        case (state)
            IDLE: if (found) begin
                state_nx = ACTIVE;
                owner_nx = win;
                rr_ptr_nx = win == OW'(NUM_REQ - 1) ? '0 : win + 1'b1;
            end
            ACTIVE: state_nx = (!req[owner] || revoke) ? RELEASE : ACTIVE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            gnt       <= '0;
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
            vga_plot  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_ptr_nx;
            gnt      <= state_nx == ACTIVE ? NUM_REQ'(1) << owner_nx : '0;
            vga_plot <= pix_ok;
            timeout  <= revoke;
            if (pix_ok) begin
                vga_x     <= ox;
                vga_y     <= oy;
                vga_color <= oc;
            end
        end
    end
endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb_vga_write_arbiter: directed and randomized checks of a round-robin and a fixed-priority arbiter
module tb_vga_write_arbiter;
    localparam int N = 3;
`ifdef ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif
    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic [N-1:0] req = '0, plot_in = '0;
    logic [9*N-1:0] x_in = '0;
    logic [8*N-1:0] y_in = '0;
    logic [3*N-1:0] color_in = '0;
    logic [N-1:0] gnt [2];
    logic busy [2], vga_plot [2], timeout [2];
    logic [8:0] vga_x [2];
    logic [7:0] vga_y [2];
    logic [2:0] vga_color [2];
    int n_tests = 0, n_fail = 0;
    int m_own [2], m_gap [2], m_ptr [2], m_age [2];
    logic [N-1:0] m_mask [2];
    logic [8:0] m_x [2];
    logic [7:0] m_y [2];
    logic [2:0] m_c [2];
    logic m_p [2], m_to [2];

    always #5 clock = ~clock;

    vga_write_arbiter #(.NUM_REQ(N), .ROUND_ROBIN(1), .WDOG_CYCLES(16)) u_rr (
        .clock(clock), .resetn(resetn), .req(req), .plot_in(plot_in), .x_in(x_in), .y_in(y_in),
        .color_in(color_in), .gnt(gnt[0]), .busy(busy[0]), .vga_x(vga_x[0]), .vga_y(vga_y[0]),
        .vga_color(vga_color[0]), .vga_plot(vga_plot[0]), .timeout(timeout[0]));
    vga_write_arbiter #(.NUM_REQ(N), .ROUND_ROBIN(0), .WDOG_CYCLES(16)) u_fx (
        .clock(clock), .resetn(resetn), .req(req), .plot_in(plot_in), .x_in(x_in), .y_in(y_in),
        .color_in(color_in), .gnt(gnt[1]), .busy(busy[1]), .vga_x(vga_x[1]), .vga_y(vga_y[1]),
        .vga_color(vga_color[1]), .vga_plot(vga_plot[1]), .timeout(timeout[1]));

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = -1; m_gap[k] = 0; m_ptr[k] = 0; m_age[k] = 0; m_mask[k] = '0;
            m_x[k] = '0; m_y[k] = '0; m_c[k] = '0; m_p[k] = 1'b0; m_to[k] = 1'b0;
        end
    endtask

    // k=0 rotates priority from m_ptr, k=1 always prefers the lowest index
    task automatic model_step();
        int o, c;
        bit hit;
        if (!resetn) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            m_p[k] = 1'b0;
            m_to[k] = 1'b0;
            if (m_own[k] >= 0) begin
                o = m_own[k];
                if (plot_in[o] && x_in[9*o +: 9] < 320 && y_in[8*o +: 8] < 240) begin
                    m_x[k] = x_in[9*o +: 9]; m_y[k] = y_in[8*o +: 8]; m_c[k] = color_in[3*o +: 3]; m_p[k] = 1'b1;
                end
                m_age[k]++;
                if (!req[o]) begin
                    m_own[k] = -1; m_gap[k] = 1;
                end else if (WD && m_age[k] >= 16) begin
                    m_own[k] = -1; m_gap[k] = 1; m_to[k] = 1'b1; m_mask[k][o] = 1'b1;
                end
            end else if (m_gap[k] > 0) begin
                m_gap[k]--;
            end else begin
                hit = 1'b0;
                for (int i = 0; i < N; i++) begin
                    c = k == 0 ? (m_ptr[k] + i) % N : i;
                    if (!hit && req[c] && !m_mask[k][c]) begin
                        hit = 1'b1; m_own[k] = c; m_age[k] = 0; m_ptr[k] = (c + 1) % N;
                    end
                end
            end
            m_mask[k] &= req;
        end
    endtask

    function automatic logic [25:0] exp_vec(int k);
        logic [N-1:0] g = m_own[k] >= 0 ? N'(1 << m_own[k]) : '0;
        return {g, m_own[k] >= 0 || m_gap[k] > 0, m_p[k], m_x[k], m_y[k], m_c[k], m_to[k]};
    endfunction

    function automatic logic [25:0] got_vec(int k);
        return {gnt[k], busy[k], vga_plot[k], vga_x[k], vga_y[k], vga_color[k], timeout[k]};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
        model_step();
    endtask

    task automatic set_pix(int i, int x, int y, int c);
        x_in[9*i +: 9] = 9'(x);
        y_in[8*i +: 8] = 8'(y);
        color_in[3*i +: 3] = 3'(c);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        req = '0;
        plot_in = '0;
        model_reset();
        cyc();
        cyc();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            n_tests++; if (got_vec(k) !== 26'd0) begin n_fail++; $display("FAIL reset_state[%0d]: got %h want 0", k, got_vec(k)); end
        end
        cyc();
        n_tests++; if (gnt[0] !== 3'b000 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_idle: gnt %b busy %b want 000/0", gnt[0], busy[0]); end
    endtask

    task automatic test_single();
        apply_reset();
        req = 3'b001;
        cyc();
        n_tests++; if (gnt[0] !== 3'b001 || busy[0] !== 1'b1) begin n_fail++; $display("FAIL t1_gnt: gnt %b busy %b want 001/1", gnt[0], busy[0]); end
        plot_in = 3'b001; set_pix(0, 5, 7, 3);
        cyc();
        n_tests++; if ({vga_plot[0], vga_x[0], vga_y[0], vga_color[0]} !== {1'b1, 9'd5, 8'd7, 3'd3}) begin
            n_fail++; $display("FAIL t1_pixel: got %b/%0d/%0d/%0d want 1/5/7/3", vga_plot[0], vga_x[0], vga_y[0], vga_color[0]); end
        plot_in = '0;
        cyc();
        n_tests++; if (vga_plot[0] !== 1'b0 || vga_x[0] !== 9'd5) begin n_fail++; $display("FAIL t1_hold: plot %b x %0d want 0/5", vga_plot[0], vga_x[0]); end
        req = '0; plot_in = 3'b001; set_pix(0, 11, 12, 1);
        cyc();
        n_tests++; if (vga_plot[0] !== 1'b1 || vga_x[0] !== 9'd11 || gnt[0] !== 3'b000) begin
            n_fail++; $display("FAIL t1_last_pixel: plot %b x %0d gnt %b want 1/11/000", vga_plot[0], vga_x[0], gnt[0]); end
        cyc();
        n_tests++; if (vga_plot[0] !== 1'b0 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL t1_release: plot %b busy %b want 0/0", vga_plot[0], busy[0]); end
        plot_in = '0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want [9] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000};
        logic [N-1:0] drive [9] = '{3'b111, 3'b110, 3'b110, 3'b110, 3'b101, 3'b101, 3'b101, 3'b011, 3'b011};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            req = drive[i];
            cyc();
            n_tests++; if (gnt[0] !== want[i]) begin n_fail++; $display("FAIL t2_rr_step%0d: gnt %b want %b", i, gnt[0], want[i]); end
        end
        cyc();
        n_tests++; if (gnt[0] !== 3'b001) begin n_fail++; $display("FAIL t2_rr_wrap: gnt %b want 001", gnt[0]); end
        req = '0; cyc(); cyc(); cyc();
    endtask

    task automatic test_fixed();
        logic [N-1:0] rr_want;
        apply_reset();
        for (int r = 0; r < 4; r++) begin
            req = 3'b110;
            cyc();
            rr_want = r % 2 ? 3'b100 : 3'b010;
            n_tests++; if (gnt[1] !== 3'b010) begin n_fail++; $display("FAIL t3_fixed_round%0d: gnt %b want 010", r, gnt[1]); end
            n_tests++; if (gnt[0] !== rr_want) begin n_fail++; $display("FAIL t3_rr_round%0d: gnt %b want %b", r, gnt[0], rr_want); end
            cyc();
            req = '0; cyc(); cyc(); cyc();
        end
    endtask

    task automatic test_bounds();
        int px [4] = '{319, 320, 10, 511};
        int py [4] = '{239, 10, 240, 255};
        apply_reset();
        req = 3'b001; plot_in = 3'b001; set_pix(0, 0, 0, 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            set_pix(0, px[i], py[i], 5);
            cyc();
            n_tests++; if ({vga_plot[0], vga_x[0], vga_y[0]} !== {i == 0, 9'd319, 8'd239}) begin
                n_fail++; $display("FAIL t4_bounds(%0d,%0d): plot %b x %0d y %0d want %b/319/239", px[i], py[i], vga_plot[0], vga_x[0], vga_y[0], i == 0); end
        end
        req = '0; plot_in = '0; cyc(); cyc();
    endtask

    task automatic test_isolation();
        apply_reset();
        req = 3'b001;
        cyc();
        plot_in = 3'b010; set_pix(1, 9, 9, 2);
        cyc();
        n_tests++; if (vga_plot[0] !== 1'b0 || vga_x[0] !== 9'd0) begin n_fail++; $display("FAIL t5_nonowner: plot %b x %0d want 0/0", vga_plot[0], vga_x[0]); end
        plot_in = 3'b011; set_pix(0, 20, 21, 4);
        cyc();
        n_tests++; if (vga_plot[0] !== 1'b1 || vga_x[0] !== 9'd20) begin n_fail++; $display("FAIL t5_owner: plot %b x %0d want 1/20", vga_plot[0], vga_x[0]); end
        #2 resetn = 1'b0;
        model_reset();
        #1;
        n_tests++; if (gnt[0] !== 3'b000 || vga_plot[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL t5_async_reset: gnt %b plot %b busy %b want 000/0/0", gnt[0], vga_plot[0], busy[0]); end
        cyc();
        n_tests++; if (got_vec(0) !== 26'd0) begin n_fail++; $display("FAIL t5_reset_hold: got %h want 0", got_vec(0)); end
        req = '0; plot_in = '0; resetn = 1'b1;
    endtask

    task automatic test_random();
        apply_reset();
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) req[i] = $urandom_range(0, 7) != 0;
                else req[i] = $urandom_range(0, 3) == 0;
                set_pix(i, $urandom_range(0, 3) == 0 ? $urandom_range(0, 511) : $urandom_range(0, 330),
                        $urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 245), $urandom_range(0, 7));
            end
            plot_in = N'($urandom);
            cyc();
            for (int k = 0; k < 2; k++) begin
                n_tests++; if (got_vec(k) !== exp_vec(k)) begin
                    n_fail++; $display("FAIL rand[%0d] cycle %0d: got %h want %h", k, t, got_vec(k), exp_vec(k)); end
            end
        end
        req = '0; plot_in = '0; cyc(); cyc(); cyc();
    endtask

`ifdef ARB_WATCHDOG_EN
    task automatic test_watchdog();
        apply_reset();
        req = 3'b011;
        for (int i = 0; i < 16; i++) begin
            cyc();
            n_tests++; if (gnt[0] !== 3'b001 || timeout[0] !== 1'b0) begin n_fail++; $display("FAIL t6_held%0d: gnt %b to %b want 001/0", i, gnt[0], timeout[0]); end
        end
        cyc();
        n_tests++; if (gnt[0] !== 3'b000 || timeout[0] !== 1'b1) begin n_fail++; $display("FAIL t6_revoke: gnt %b to %b want 000/1", gnt[0], timeout[0]); end
        cyc();
        n_tests++; if (timeout[0] !== 1'b0) begin n_fail++; $display("FAIL t6_pulse: to %b want 0", timeout[0]); end
        cyc();
        n_tests++; if (gnt[0] !== 3'b010) begin n_fail++; $display("FAIL t6_next: gnt %b want 010", gnt[0]); end
        req = 3'b001;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_tests++; if (gnt[0] !== 3'b000) begin n_fail++; $display("FAIL t6_masked%0d: gnt %b want 000", i, gnt[0]); end
        end
        req = 3'b000; cyc();
        req = 3'b001; cyc();
        n_tests++; if (gnt[0] !== 3'b001) begin n_fail++; $display("FAIL t6_unmask: gnt %b want 001", gnt[0]); end
        req = '0; cyc(); cyc(); cyc();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_fixed();
        test_bounds();
        test_isolation();
`ifdef ARB_WATCHDOG_EN
        test_watchdog();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
